// File: rtl/pio_edge_irq_n.sv
// ---------------------------------------------------------------------------
// pio_edge_irq_n
//
// Purpose:
//   Interrupt-capable, multi-bit input PIO for the Avalon-MM peripheral bus.
//   Each external input is synchronised and then debounced by a run-time
//   programmable filter. Rising and/or falling edges of the filtered value
//   are captured into a write-1-to-clear register. A level interrupt is
//   raised while any captured, unmasked bit is set.
//
// Ports:
//   clk         system clock, the only clock domain
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 RAW, 2 IRQ_MASK, 3 EDGE_CAP,
//               4 RISE_EN, 5 FALL_EN, 6 FILTER, 7 IRQ_STAT)
//   chipselect  slave select, qualifies writes only
//   write_n     active-low write strobe
//   writedata   write data, bits above the register width are ignored
//   in_port     asynchronous external inputs
//   readdata    registered read data, valid one cycle after address
//   irq         interrupt request, active high
// ---------------------------------------------------------------------------
module pio_edge_irq_n #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      FILT_W      = 8,
    parameter logic [WIDTH-1:0] RISE_EN_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RAW      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [2:0] ADDR_FILTER   = 3'd6;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd7;

    logic [WIDTH-1:0]  syncMeta_q;
    logic [WIDTH-1:0]  sync_q;
    logic [WIDTH-1:0]  filt_q;
    logic [WIDTH-1:0]  filt_d;
    logic [WIDTH-1:0]  filtPrev_q;
    logic [FILT_W-1:0] cnt_q [WIDTH];
    logic [FILT_W-1:0] cnt_d [WIDTH];
    logic [FILT_W:0]   cntPlus [WIDTH];

    logic [WIDTH-1:0]  irqMask_q;
    logic [WIDTH-1:0]  edgeCap_q;
    logic [WIDTH-1:0]  edgeCap_d;
    logic [WIDTH-1:0]  riseEn_q;
    logic [WIDTH-1:0]  fallEn_q;
    logic [FILT_W-1:0] filter_q;
    logic [31:0]       readdata_q;
    logic [31:0]       readdata_d;

    logic              wrEn;
    logic [WIDTH-1:0]  wrData;
    logic [WIDTH-1:0]  riseEv;
    logic [WIDTH-1:0]  fallEv;
    logic [WIDTH-1:0]  edgeEv;
    logic [WIDTH-1:0]  capClear;
    logic              unusedWriteBits;

    assign wrEn            = chipselect && !write_n;
    assign wrData          = writedata[WIDTH-1:0];
    assign unusedWriteBits = &{1'b0, writedata};

    // Two-flop synchroniser per bit: in_port -> syncMeta_q -> sync_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta_q <= '0;
            sync_q     <= '0;
        end else begin
            syncMeta_q <= in_port;
            sync_q     <= syncMeta_q;
        end
    end

    // Debounce filter next-state. The counter is widened by one bit so the
    // "count+1 >= FILTER" compare never wraps, and ">=" rather than "=="
    // lets a FILTER reduction below the running count resolve on the next
    // cycle instead of leaving the bit stuck.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]   = '0;
            cntPlus[i] = {1'b0, cnt_q[i]} + {{FILT_W{1'b0}}, 1'b1};
            if (filter_q == '0) begin
                filt_d[i] = sync_q[i];
            end else if (sync_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cntPlus[i] >= {1'b0, filter_q}) begin
                filt_d[i] = sync_q[i];
            end else if (&cnt_q[i]) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cntPlus[i][FILT_W-1:0];
            end
        end
    end

    // Filtered value, its one-cycle-delayed copy for edge detection, and the
    // per-bit debounce counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= '0;
            filtPrev_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q     <= filt_d;
            filtPrev_q <= filt_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Edge events and capture register. A new event is ORed in after the
    // write-1-to-clear, so an event landing in the same cycle as a clear of
    // that bit is kept.
    always_comb begin
        riseEv    = filt_q & ~filtPrev_q;
        fallEv    = ~filt_q & filtPrev_q;
        edgeEv    = (riseEv & riseEn_q) | (fallEv & fallEn_q);
        capClear  = (wrEn && (address == ADDR_EDGE_CAP)) ? wrData : '0;
        edgeCap_d = edgeEv | (edgeCap_q & ~capClear);
    end

    // Software-visible control registers and the capture register.
    // Read-only addresses have no write decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqMask_q <= '0;
            edgeCap_q <= '0;
            riseEn_q  <= RISE_EN_RST;
            fallEn_q  <= '0;
            filter_q  <= '0;
        end else begin
            edgeCap_q <= edgeCap_d;
            if (wrEn) begin
                case (address)
                    ADDR_IRQ_MASK: irqMask_q <= wrData;
                    ADDR_RISE_EN:  riseEn_q  <= wrData;
                    ADDR_FALL_EN:  fallEn_q  <= wrData;
                    ADDR_FILTER:   filter_q  <= writedata[FILT_W-1:0];
                    default:       ;
                endcase
            end
        end
    end

    // Read mux, zero-extended to the bus width. Reads ignore chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[WIDTH-1:0]  = filt_q;
            ADDR_RAW:      readdata_d[WIDTH-1:0]  = sync_q;
            ADDR_IRQ_MASK: readdata_d[WIDTH-1:0]  = irqMask_q;
            ADDR_EDGE_CAP: readdata_d[WIDTH-1:0]  = edgeCap_q;
            ADDR_RISE_EN:  readdata_d[WIDTH-1:0]  = riseEn_q;
            ADDR_FALL_EN:  readdata_d[WIDTH-1:0]  = fallEn_q;
            ADDR_FILTER:   readdata_d[FILT_W-1:0] = filter_q;
            ADDR_IRQ_STAT: readdata_d[WIDTH-1:0]  = edgeCap_q & irqMask_q;
            default:       readdata_d = '0;
        endcase
    end

    // Registered read data, one cycle after the address is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_pio_edge_irq_n.sv
// ---------------------------------------------------------------------------
// tb_pio_edge_irq_n
//
// Purpose:
//   Scenario-based bench for pio_edge_irq_n with default parameters
//   (WIDTH=8, FILT_W=8, RISE_EN_RST=0xFF). Expected read values are queued
//   when an address is presented and compared when readdata is produced.
// ---------------------------------------------------------------------------
module tb_pio_edge_irq_n;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    logic [31:0] expQ [$];
    int          nChecks;
    int          nFails;

    pio_edge_irq_n dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // Free-running 100 MHz clock; stimulus and sampling happen on negedges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] expTab [8];
        logic [31:0] expVal;
        reset_n    = 1'b0;
        in_port    = '0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        waitCycles(3);
        nChecks++;
        if (readdata !== 32'h0) begin
            nFails++;
            $display("[TB] FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_irq: got %b expected %b", irq, 1'b0);
        end
        reset_n = 1'b1;
        expTab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0};
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            expQ.push_back(expTab[a]);
            @(negedge clk);
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, readdata, expVal);
            end
        end
    endtask

    task automatic test_rise_capture();
        logic [31:0] expVal;
        in_port[3] = 1'b1;
        address    = 3'd3;
        for (int k = 1; k <= 5; k++) begin
            expQ.push_back((k == 5) ? 32'h08 : 32'h00);
            @(negedge clk);
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL rise_latency_e%0d: got %h expected %h", k, readdata, expVal);
            end
        end
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL rise_irq_masked: got %b expected %b", irq, 1'b0);
        end
        busWrite(3'd2, 32'h08);
        nChecks++;
        if (irq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL rise_irq_unmasked: got %b expected %b", irq, 1'b1);
        end
        busWrite(3'd3, 32'h08);
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL rise_irq_cleared: got %b expected %b", irq, 1'b0);
        end
        address = 3'd3;
        expQ.push_back(32'h00);
        @(negedge clk);
        expVal = expQ.pop_front();
        nChecks++;
        if (readdata !== expVal) begin
            nFails++;
            $display("[TB] FAIL rise_w1c: got %h expected %h", readdata, expVal);
        end
    endtask

    task automatic test_fall_capture();
        logic [2:0]  addrTab [5];
        logic [31:0] expTab [5];
        logic [31:0] expVal;
        busWrite(3'd4, 32'h00);
        busWrite(3'd5, 32'h01);
        in_port[0] = 1'b1;
        waitCycles(5);
        in_port[0] = 1'b0;
        waitCycles(6);
        addrTab = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd7};
        expTab  = '{32'h01, 32'h08, 32'h08, 32'h08, 32'h00};
        for (int j = 0; j < 5; j++) begin
            address = addrTab[j];
            expQ.push_back(expTab[j]);
            @(negedge clk);
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL fall_addr%0d: got %h expected %h", addrTab[j], readdata, expVal);
            end
        end
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL fall_irq: got %b expected %b", irq, 1'b0);
        end
        busWrite(3'd3, 32'h01);
        busWrite(3'd4, 32'hFF);
        busWrite(3'd5, 32'h00);
    endtask

    task automatic test_filter();
        logic [31:0] expVal;
        busWrite(3'd6, 32'h04);
        in_port[1] = 1'b1;
        waitCycles(3);
        in_port[1] = 1'b0;
        waitCycles(6);
        address = 3'd0;
        expQ.push_back(32'h08);
        @(negedge clk);
        address = 3'd3;
        expQ.push_back(32'h00);
        expVal = expQ.pop_front();
        nChecks++;
        if (readdata !== expVal) begin
            nFails++;
            $display("[TB] FAIL glitch_data: got %h expected %h", readdata, expVal);
        end
        @(negedge clk);
        expVal = expQ.pop_front();
        nChecks++;
        if (readdata !== expVal) begin
            nFails++;
            $display("[TB] FAIL glitch_cap: got %h expected %h", readdata, expVal);
        end

        in_port[1] = 1'b1;
        address    = 3'd3;
        for (int k = 1; k <= 8; k++) begin
            expQ.push_back((k == 8) ? 32'h02 : 32'h00);
            @(negedge clk);
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL filter_cap_e%0d: got %h expected %h", k, readdata, expVal);
            end
        end

        busWrite(3'd6, 32'h08);
        in_port[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) begin
                address    = 3'd6;
                writedata  = 32'h02;
                chipselect = 1'b1;
                write_n    = 1'b0;
                expQ.push_back(32'h08);
            end else begin
                address = 3'd0;
                expQ.push_back((k == 8) ? 32'h08 : 32'h0A);
            end
            @(negedge clk);
            chipselect = 1'b0;
            write_n    = 1'b1;
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL filter_shrink_e%0d: got %h expected %h", k, readdata, expVal);
            end
        end
        address = 3'd6;
        expQ.push_back(32'h02);
        @(negedge clk);
        expVal = expQ.pop_front();
        nChecks++;
        if (readdata !== expVal) begin
            nFails++;
            $display("[TB] FAIL filter_reg: got %h expected %h", readdata, expVal);
        end
        busWrite(3'd6, 32'h00);
        busWrite(3'd3, 32'hFF);
    endtask

    task automatic test_back_to_back();
        logic [31:0] expVal;
        in_port[2] = 1'b1;
        waitCycles(5);
        busWrite(3'd2, 32'h04);
        nChecks++;
        if (irq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL race_irq_initial: got %b expected %b", irq, 1'b1);
        end
        in_port[2] = 1'b0;
        waitCycles(5);
        in_port[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                address    = 3'd3;
                writedata  = 32'h04;
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
            @(negedge clk);
            chipselect = 1'b0;
            write_n    = 1'b1;
            nChecks++;
            if (irq !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL race_irq_e%0d: got %b expected %b", k, irq, 1'b1);
            end
        end
        address = 3'd3;
        expQ.push_back(32'h04);
        @(negedge clk);
        expVal = expQ.pop_front();
        nChecks++;
        if (readdata !== expVal) begin
            nFails++;
            $display("[TB] FAIL race_cap: got %h expected %h", readdata, expVal);
        end
        busWrite(3'd3, 32'h04);
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL race_irq_after_clear: got %b expected %b", irq, 1'b0);
        end
    endtask

    task automatic test_ro_writes();
        logic [31:0] expTab [8];
        logic [31:0] expVal;
        busWrite(3'd0, 32'hFF);
        busWrite(3'd1, 32'hFF);
        busWrite(3'd7, 32'hFF);
        expTab = '{32'h0C, 32'h0C, 32'h04, 32'h00, 32'hFF, 32'h00, 32'h00, 32'h00};
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            expQ.push_back(expTab[a]);
            @(negedge clk);
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL ro_reg%0d: got %h expected %h", a, readdata, expVal);
            end
        end
        busWrite(3'd2, 32'hFFFF_FF00);
        address = 3'd2;
        expQ.push_back(32'h00);
        @(negedge clk);
        expVal = expQ.pop_front();
        nChecks++;
        if (readdata !== expVal) begin
            nFails++;
            $display("[TB] FAIL mask_upper_bits: got %h expected %h", readdata, expVal);
        end
    endtask

    task automatic test_reset_midcount();
        logic [2:0]  addrTab [4];
        logic [31:0] expTab [4];
        logic [31:0] expVal;
        in_port = 8'h00;
        waitCycles(5);
        busWrite(3'd3, 32'hFF);
        in_port = 8'h55;
        waitCycles(6);
        busWrite(3'd2, 32'h55);
        address = 3'd3;
        expQ.push_back(32'h55);
        @(negedge clk);
        expVal = expQ.pop_front();
        nChecks++;
        if (readdata !== expVal) begin
            nFails++;
            $display("[TB] FAIL pre_reset_cap: got %h expected %h", readdata, expVal);
        end
        busWrite(3'd6, 32'h04);
        in_port = 8'h00;
        waitCycles(4);
        #2;
        reset_n = 1'b0;
        #1;
        nChecks++;
        if (readdata !== 32'h0) begin
            nFails++;
            $display("[TB] FAIL async_reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL async_reset_irq: got %b expected %b", irq, 1'b0);
        end
        in_port = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        address = 3'd3;
        for (int k = 1; k <= 5; k++) begin
            expQ.push_back((k == 5) ? 32'hFF : 32'h00);
            @(negedge clk);
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL post_reset_cap_e%0d: got %h expected %h", k, readdata, expVal);
            end
        end
        addrTab = '{3'd6, 3'd4, 3'd5, 3'd2};
        expTab  = '{32'h00, 32'hFF, 32'h00, 32'h00};
        for (int j = 0; j < 4; j++) begin
            address = addrTab[j];
            expQ.push_back(expTab[j]);
            @(negedge clk);
            expVal = expQ.pop_front();
            nChecks++;
            if (readdata !== expVal) begin
                nFails++;
                $display("[TB] FAIL post_reset_addr%0d: got %h expected %h", addrTab[j], readdata, expVal);
            end
        end
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL post_reset_irq: got %b expected %b", irq, 1'b0);
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        nChecks = 0;
        nFails  = 0;
        $display("[TB] starting pio_edge_irq_n scenarios");
        test_reset();
        test_rise_capture();
        test_fall_capture();
        test_filter();
        test_back_to_back();
        test_ro_writes();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
